// File: rtl/scalar_multiplier.sv
// ----------------------------------------------------------------------------
// scalar_multiplier
//   Single-cycle multiply unit for the scalar ALU execute stage. Produces the
//   low N bits of the unsigned product A*B together with N/Z/C/V status flags,
//   all registered, plus a valid strobe marking a freshly computed result.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous, active-high reset (clears every output)
//   valid_in   A/B carry a multiply request this cycle
//   A, B       N-bit operands (treated as unsigned for the product)
//   R          low N bits of the product
//   N_flag     R[N-1]
//   Z_flag     R == 0
//   C_flag     upper half of the full product is non-zero
//   V_flag     always 0 (no signed-overflow detection)
//   valid_out  R/flags hold the result of the request taken on the last edge
// ----------------------------------------------------------------------------
module scalar_multiplier #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] R,
    output logic         N_flag,
    output logic         Z_flag,
    output logic         C_flag,
    output logic         V_flag,
    output logic         valid_out
);

    localparam int unsigned PW = 2 * N;

    // Registered result payload.
    typedef struct packed {
        logic [N-1:0] r;
        logic         n;
        logic         z;
        logic         c;
    } result_t;

    logic [PW-1:0] prod_c;
    result_t       res_d,   res_q;
    logic          valid_d, valid_q;

    // Full-width unsigned product; the low half is the same for signed operands.
    always_comb begin
        prod_c = PW'(A) * PW'(B);
    end

    // Capture a new result only on a request; otherwise hold the last one.
    always_comb begin
        res_d   = res_q;
        valid_d = 1'b0;
        if (valid_in) begin
            res_d.r = prod_c[N-1:0];
            res_d.n = prod_c[N-1];
            res_d.z = (prod_c[N-1:0] == '0);
            res_d.c = (prod_c[PW-1:N] != '0);
            valid_d = 1'b1;
        end
    end

    // Reset clears Z as well, even though R reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign R         = res_q.r;
    assign N_flag    = res_q.n;
    assign Z_flag    = res_q.z;
    assign C_flag    = res_q.c;
    assign V_flag    = 1'b0;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_scalar_multiplier.sv
// ----------------------------------------------------------------------------
// tb_scalar_multiplier
//   Self-checking bench for scalar_multiplier at N=32. Expected results are
//   queued when a request is driven and compared one edge later.
// ----------------------------------------------------------------------------
module tb_scalar_multiplier;

    localparam int unsigned N = 32;

    typedef struct packed {
        logic [N-1:0] r;
        logic         n;
        logic         z;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_in = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] R;
    logic         N_flag, Z_flag, C_flag, V_flag, valid_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t held = '0;

    scalar_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .A         (A),
        .B         (B),
        .R         (R),
        .N_flag    (N_flag),
        .Z_flag    (Z_flag),
        .C_flag    (C_flag),
        .V_flag    (V_flag),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit unsigned product, flags derived from the spec rules.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0] p;
        exp_t        e;
        p   = 64'(a) * 64'(b);
        e.r = p[31:0];
        e.n = p[31];
        e.z = (p[31:0] == 32'd0);
        e.c = (p[63:32] != 32'd0);
        return e;
    endfunction

    task automatic check_outputs(input string tag, input logic exp_valid);
        chk({tag, ".valid"}, 64'(valid_out), 64'(exp_valid));
        chk({tag, ".R"},     64'(R),         64'(held.r));
        chk({tag, ".N"},     64'(N_flag),    64'(held.n));
        chk({tag, ".Z"},     64'(Z_flag),    64'(held.z));
        chk({tag, ".C"},     64'(C_flag),    64'(held.c));
        chk({tag, ".V"},     64'(V_flag),    64'd0);
    endtask

    // Drive one cycle of stimulus, then check just after the next rising edge.
    task automatic step(input string tag, input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
        logic exp_valid;
        valid_in = v;
        A        = a;
        B        = b;
        if (v) exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        if (exp_q.size() > 0) begin
            held      = exp_q.pop_front();
            exp_valid = 1'b1;
        end
        check_outputs(tag, exp_valid);
    endtask

    initial begin
        // Asynchronous reset with a live request on the inputs.
        valid_in = 1'b1;
        A        = 32'd5;
        B        = 32'd5;
        #2 rst = 1'b1;
        #1;
        held = '0;
        check_outputs("rst_async", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_hold", 1'b0);
        rst = 1'b0;
        step("rst_release", 1'b1, 32'd5, 32'd5);

        // Zero then one, back-to-back.
        step("zero", 1'b1, 32'd0, 32'd0);
        step("one",  1'b1, 32'd1, 32'd1);

        // Negative result.
        step("neg", 1'b1, 32'hFFFF_FFFF, 32'd1);

        // Carry out, two patterns back-to-back.
        step("carry_a", 1'b1, 32'h0001_0000, 32'h0001_0000);
        step("carry_b", 1'b1, 32'h8000_0000, 32'd2);

        // Hold: random operands with valid_in low leave the result untouched.
        step("pre_hold", 1'b1, 32'h1234_5678, 32'h0000_0F0F);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, $urandom(), $urandom());
        end

        // Mid-stream reset discards the in-flight request.
        step("pre_rst", 1'b1, 32'd7, 32'd7);
        valid_in = 1'b1;
        A        = 32'd9;
        B        = 32'd9;
        #3 rst = 1'b1;
        #1;
        held = '0;
        check_outputs("mid_rst_async", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("mid_rst_hold", 1'b0);
        rst = 1'b0;
        step("post_rst_idle", 1'b0, 32'd3, 32'd3);

        // Random back-to-back requests.
        for (int i = 0; i < 1000; i++) begin
            step("rand", 1'b1, $urandom(), $urandom());
        end

        // Drain: one idle cycle, result held, valid drops.
        step("drain", 1'b0, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
